intr_ctrl: RTL

INTR_CTRL -- requirements
Module: intr_ctrl

---
 rtl/intr_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/intr_ctrl.sv
// Four-source interrupt controller: edge-detected events latch into PENDING,
// and a three-state FSM presents one masked pending source at a time as a one-hot request.
module intr_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  src_evt,
   input  logic        irq_ack,
   input  logic        irq_eoi,
   input  logic        reg_we,
   input  logic [1:0]  reg_addr,
   input  logic [31:0] reg_wdata,
   output logic [31:0] reg_rdata,
   output logic [3:0]  done,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REQ      = 2'd1,
      WAIT_EOI = 2'd2
   } state_e;

   localparam logic [1:0] ADDR_MASK   = 2'd0;
   localparam logic [1:0] ADDR_PEND   = 2'd1;
   localparam logic [1:0] ADDR_STATUS = 2'd2;
   localparam logic [1:0] ADDR_OVF    = 2'd3;

   state_e          state_q;
   logic [1:0]      sel_q;
   logic [3:0]      done_q;
   logic            busy_q;

   logic [3:0]      src_evt_q;
   logic [3:0]      mask_q,    mask_d;
   logic [3:0]      pending_q, pending_d;
   logic [3:0][7:0] ovf_q,     ovf_d;

   logic [3:0]      evt;
   logic [3:0]      w1c;
   logic [3:0]      ack_clr;
   logic [3:0]      clr;
   logic [3:0]      req_vec;
   logic [1:0]      req_sel;
   logic            unused_wdata;

   function automatic logic [3:0] onehot(input logic [1:0] idx);
      onehot = 4'b0001 << idx;
   endfunction

   // Bit 0 is highest priority, so scan downward and let the lowest hit win.
   function automatic logic [1:0] lowest(input logic [3:0] v);
      lowest = 2'd0;
      for (int unsigned i = 4; i > 0; i--) begin
         if (v[i-1]) lowest = 2'(i - 1);
      end
   endfunction

   assign unused_wdata = ^reg_wdata[31:4];

   always_comb begin
      evt     = src_evt & ~src_evt_q;
      w1c     = (reg_we && reg_addr == ADDR_PEND) ? reg_wdata[3:0] : '0;
      ack_clr = (state_q == REQ && irq_ack) ? onehot(sel_q) : '0;
      clr     = w1c | ack_clr;
      // A fresh event outranks any clear landing on the same bit.
      pending_d = (pending_q & ~clr) | evt;
      mask_d    = (reg_we && reg_addr == ADDR_MASK) ? reg_wdata[3:0] : mask_q;
   end

   // Overflow counts only events that hit an already-pending bit not being cleared now.
   always_comb begin
      ovf_d = ovf_q;
      if (reg_we && reg_addr == ADDR_OVF) begin
         ovf_d = '0;
      end else begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (evt[i] && pending_q[i] && !clr[i] && ovf_q[i] != 8'hFF) begin
               ovf_d[i] = ovf_q[i] + 8'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         src_evt_q <= '0;
         mask_q    <= '0;
         pending_q <= '0;
         ovf_q     <= '0;
      end else begin
         src_evt_q <= src_evt;
         mask_q    <= mask_d;
         pending_q <= pending_d;
         ovf_q     <= ovf_d;
      end
   end

   assign req_vec = pending_q & mask_q;
   assign req_sel = lowest(req_vec);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sel_q   <= '0;
         done_q  <= '0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (|req_vec) begin
                  state_q <= REQ;
                  sel_q   <= req_sel;
                  done_q  <= onehot(req_sel);
                  busy_q  <= 1'b1;
               end
            end
            REQ: begin
               if (irq_ack) begin
                  state_q <= WAIT_EOI;
                  done_q  <= '0;
               end else if (!mask_q[sel_q]) begin
                  state_q <= IDLE;
                  done_q  <= '0;
                  busy_q  <= 1'b0;
               end
            end
            WAIT_EOI: begin
               if (irq_eoi) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               done_q  <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      reg_rdata = '0;
      case (reg_addr)
         ADDR_MASK:   reg_rdata = {28'd0, mask_q};
         ADDR_PEND:   reg_rdata = {28'd0, pending_q};
         ADDR_STATUS: reg_rdata = {27'd0, busy_q, state_q, sel_q};
         ADDR_OVF:    reg_rdata = ovf_q;
         default:     reg_rdata = '0;
      endcase
   end

   assign done = done_q;
   assign busy = busy_q;

endmodule
